// File: rtl/red_pitaya_sort_pulse_if.sv
// System-bus bundle for the sort-pulse generator.
// The master drives the request; the slave returns a registered ack and read data.
interface red_pitaya_sort_pulse_if;
  logic [31:0] sys_addr;
  logic [31:0] sys_wdata;
  logic        sys_wen;
  logic        sys_ren;
  logic [31:0] sys_rdata;
  logic        sys_err;
  logic        sys_ack;

  modport master (
    output sys_addr, sys_wdata, sys_wen, sys_ren,
    input  sys_rdata, sys_err, sys_ack
  );

  modport slave (
    input  sys_addr, sys_wdata, sys_wen, sys_ren,
    output sys_rdata, sys_err, sys_ack
  );
endinterface

// File: rtl/red_pitaya_sort_pulse.sv
// Sort-trigger to bipolar DAC burst generator with post-burst holdoff,
// missed-trigger counting and a bus-programmable register file.
module red_pitaya_sort_pulse #(
  parameter int DWO = 14,
  parameter int CW  = 32
) (
  input  logic                  adc_clk_i,
  input  logic                  adc_rst_i,
  input  logic                  sort_trig_i,
  output logic signed [DWO-1:0] dac_o,
  output logic                  busy_o,
  red_pitaya_sort_pulse_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BURST   = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic                  en_q, en_d, neg_first_q, neg_first_d;
  logic                  sw_trig_q, sw_trig_d, clr_q, clr_d;
  logic [DWO-2:0]        amp_q, amp_d;
  logic [CW-1:0]         hp_q, hp_d, n_half_q, n_half_d, holdoff_q, holdoff_d;
  logic [CW-1:0]         burst_cnt_q, burst_cnt_d, missed_cnt_q, missed_cnt_d;
  logic                  ack_q, ack_d;
  logic [31:0]           rdata_q, rdata_d;

  state_t                state_q, state_d;
  logic                  trig_q, trig_d;
  logic signed [DWO-1:0] dac_q, dac_d;
  logic                  busy_q, busy_d, pol_q, pol_d;
  logic [DWO-2:0]        amp_sh_q, amp_sh_d;
  logic [CW-1:0]         hp_sh_q, hp_sh_d, n_half_sh_q, n_half_sh_d, ho_sh_q, ho_sh_d;
  logic [CW-1:0]         hp_cnt_q, hp_cnt_d, half_cnt_q, half_cnt_d, ho_cnt_q, ho_cnt_d;

  logic                  rise_s, burst_inc_s, missed_inc_s;
  logic [19:0]           addr_s;
  logic signed [DWO-1:0] start_mag_s, run_mag_s;
  logic                  unused_addr_s;

  assign addr_s        = bus.sys_addr[19:0];
  assign unused_addr_s = ^bus.sys_addr[31:20];
  assign dac_o         = dac_q;
  assign busy_o        = busy_q;
  assign bus.sys_rdata = rdata_q;
  assign bus.sys_ack   = ack_q;
  assign bus.sys_err   = 1'b0;

  // Register file: writes, self-clearing command pulses and registered readback.
  always_comb begin
    en_d        = en_q;
    neg_first_d = neg_first_q;
    sw_trig_d   = 1'b0;
    clr_d       = 1'b0;
    amp_d       = amp_q;
    hp_d        = hp_q;
    n_half_d    = n_half_q;
    holdoff_d   = holdoff_q;
    ack_d       = bus.sys_wen | bus.sys_ren;
    rdata_d     = 32'd0;
    if (bus.sys_wen) begin
      case (addr_s)
        20'h00000: begin
          en_d        = bus.sys_wdata[0];
          neg_first_d = bus.sys_wdata[1];
          sw_trig_d   = bus.sys_wdata[2];
          clr_d       = bus.sys_wdata[3];
        end
        20'h00004: amp_d     = bus.sys_wdata[DWO-2:0];
        20'h00008: hp_d      = CW'(bus.sys_wdata);
        20'h0000C: n_half_d  = CW'(bus.sys_wdata);
        20'h00010: holdoff_d = CW'(bus.sys_wdata);
        default:   amp_d     = amp_q;
      endcase
    end else begin
      amp_d = amp_q;
    end
    if (bus.sys_ren) begin
      case (addr_s)
        20'h00000: rdata_d = {30'd0, neg_first_q, en_q};
        20'h00004: rdata_d = 32'(amp_q);
        20'h00008: rdata_d = 32'(hp_q);
        20'h0000C: rdata_d = 32'(n_half_q);
        20'h00010: rdata_d = 32'(holdoff_q);
        20'h00020: rdata_d = {29'd0, busy_q, state_q};
        20'h00024: rdata_d = 32'(burst_cnt_q);
        20'h00028: rdata_d = 32'(missed_cnt_q);
        default:   rdata_d = 32'd0;
      endcase
    end else begin
      rdata_d = 32'd0;
    end
  end

  // Burst sequencer: trigger qualification, half-period timing, holdoff and event counters.
  always_comb begin
    trig_d       = sort_trig_i;
    rise_s       = (sort_trig_i & ~trig_q) | sw_trig_q;
    start_mag_s  = {1'b0, amp_q};
    run_mag_s    = {1'b0, amp_sh_q};
    state_d      = state_q;
    dac_d        = dac_q;
    busy_d       = busy_q;
    pol_d        = pol_q;
    amp_sh_d     = amp_sh_q;
    hp_sh_d      = hp_sh_q;
    n_half_sh_d  = n_half_sh_q;
    ho_sh_d      = ho_sh_q;
    hp_cnt_d     = hp_cnt_q;
    half_cnt_d   = half_cnt_q;
    ho_cnt_d     = ho_cnt_q;
    burst_inc_s  = 1'b0;
    missed_inc_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise_s && en_q) begin
          amp_sh_d    = amp_q;
          hp_sh_d     = (hp_q == '0) ? CNT_ONE : hp_q;
          n_half_sh_d = n_half_q;
          ho_sh_d     = holdoff_q;
          pol_d       = neg_first_q;
          hp_cnt_d    = CNT_ONE;
          half_cnt_d  = '0;
          ho_cnt_d    = CNT_ONE;
          burst_inc_s = 1'b1;
          if (n_half_q != '0) begin
            state_d = S_BURST;
            busy_d  = 1'b1;
            dac_d   = neg_first_q ? -start_mag_s : start_mag_s;
          end else if (holdoff_q != '0) begin
            state_d = S_HOLDOFF;
            busy_d  = 1'b1;
            dac_d   = '0;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            dac_d   = '0;
          end
        end else begin
          dac_d  = '0;
          busy_d = 1'b0;
        end
      end
      S_BURST: begin
        if (!en_q) begin
          state_d = S_IDLE;
          dac_d   = '0;
          busy_d  = 1'b0;
        end else begin
          missed_inc_s = rise_s;
          if (hp_cnt_q >= hp_sh_q) begin
            if (half_cnt_q + CNT_ONE == n_half_sh_q) begin
              dac_d    = '0;
              ho_cnt_d = CNT_ONE;
              if (ho_sh_q != '0) begin
                state_d = S_HOLDOFF;
                busy_d  = 1'b1;
              end else begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
              end
            end else begin
              // pol_q still holds the polarity of the half-period just finished
              pol_d      = ~pol_q;
              dac_d      = pol_q ? run_mag_s : -run_mag_s;
              hp_cnt_d   = CNT_ONE;
              half_cnt_d = half_cnt_q + CNT_ONE;
            end
          end else begin
            hp_cnt_d = hp_cnt_q + CNT_ONE;
          end
        end
      end
      S_HOLDOFF: begin
        dac_d = '0;
        if (!en_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          missed_inc_s = rise_s;
          if (ho_cnt_q >= ho_sh_q) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else begin
            ho_cnt_d = ho_cnt_q + CNT_ONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        dac_d   = '0;
        busy_d  = 1'b0;
      end
    endcase

    if (clr_q) begin
      burst_cnt_d = '0;
    end else if (burst_inc_s && (burst_cnt_q != CNT_MAX)) begin
      burst_cnt_d = burst_cnt_q + CNT_ONE;
    end else begin
      burst_cnt_d = burst_cnt_q;
    end
    if (clr_q) begin
      missed_cnt_d = '0;
    end else if (missed_inc_s && (missed_cnt_q != CNT_MAX)) begin
      missed_cnt_d = missed_cnt_q + CNT_ONE;
    end else begin
      missed_cnt_d = missed_cnt_q;
    end
  end

  // All state flops; reset is synchronous and wins even in the middle of a burst.
  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      en_q         <= 1'b0;
      neg_first_q  <= 1'b0;
      sw_trig_q    <= 1'b0;
      clr_q        <= 1'b0;
      amp_q        <= '0;
      hp_q         <= CW'(1250);
      n_half_q     <= CW'(20);
      holdoff_q    <= '0;
      burst_cnt_q  <= '0;
      missed_cnt_q <= '0;
      ack_q        <= 1'b0;
      rdata_q      <= 32'd0;
      state_q      <= S_IDLE;
      trig_q       <= 1'b0;
      dac_q        <= '0;
      busy_q       <= 1'b0;
      pol_q        <= 1'b0;
      amp_sh_q     <= '0;
      hp_sh_q      <= CNT_ONE;
      n_half_sh_q  <= '0;
      ho_sh_q      <= '0;
      hp_cnt_q     <= '0;
      half_cnt_q   <= '0;
      ho_cnt_q     <= '0;
    end else begin
      en_q         <= en_d;
      neg_first_q  <= neg_first_d;
      sw_trig_q    <= sw_trig_d;
      clr_q        <= clr_d;
      amp_q        <= amp_d;
      hp_q         <= hp_d;
      n_half_q     <= n_half_d;
      holdoff_q    <= holdoff_d;
      burst_cnt_q  <= burst_cnt_d;
      missed_cnt_q <= missed_cnt_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      state_q      <= state_d;
      trig_q       <= trig_d;
      dac_q        <= dac_d;
      busy_q       <= busy_d;
      pol_q        <= pol_d;
      amp_sh_q     <= amp_sh_d;
      hp_sh_q      <= hp_sh_d;
      n_half_sh_q  <= n_half_sh_d;
      ho_sh_q      <= ho_sh_d;
      hp_cnt_q     <= hp_cnt_d;
      half_cnt_q   <= half_cnt_d;
      ho_cnt_q     <= ho_cnt_d;
    end
  end
endmodule
